// File: rtl/game_tick_scheduler.sv
// Prescaled game tick with per-player move counters and a round-robin shared update engine.
// Define TICK_OVR_CNT_EN to add a saturating 8-bit overrun event counter on ovr_cnt.
module game_tick_scheduler #(
    parameter int DIV   = 25,
    parameter int SPD_W = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             pause,
    input  logic [SPD_W-1:0] spd_p1,
    input  logic [SPD_W-1:0] spd_p2,
    input  logic             upd_done,
    output logic             base_tick,
    output logic             upd_start,
    output logic             upd_sel,
    output logic             busy,
    output logic [1:0]       overrun,
    output logic [7:0]       ovr_cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0][SPD_W-1:0] mcnt_q, mcnt_d;
    logic [1:0][SPD_W-1:0] spd;
    logic [1:0] pend_q, pend_d;
    logic [1:0] overrun_q, overrun_d;
    logic [1:0] elapse, clr, ovr_ev;
    logic sel_q, sel_d;
    logic last_q, last_d;

    assign spd       = {spd_p2, spd_p1};
    assign base_tick = (pcnt_q == PW'(DIV - 1)) && !pause;

    always_comb begin
        pcnt_d = pcnt_q;
        if (!pause) begin
            pcnt_d = (pcnt_q == PW'(DIV - 1)) ? '0 : pcnt_q + PW'(1);
        end
    end

    // A speed of 0 elapses on every tick, the same as a speed of 1.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            elapse[p] = base_tick &&
                (({1'b0, mcnt_q[p]} + (SPD_W + 1)'(1)) >= {1'b0, spd[p]});
            mcnt_d[p] = mcnt_q[p];
            if (base_tick) begin
                mcnt_d[p] = elapse[p] ? '0 : mcnt_q[p] + SPD_W'(1);
            end
            clr[p] = (state_q == START) && (sel_q == 1'(p));
        end
        pend_d    = (pend_q & ~clr) | elapse;
        ovr_ev    = elapse & pend_q & ~clr;
        overrun_d = overrun_q | ovr_ev;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = START;
                    sel_d   = (&pend_q) ? ~last_q : pend_q[1];
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (upd_done) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            mcnt_q    <= '0;
            pend_q    <= '0;
            overrun_q <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            mcnt_q    <= mcnt_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
        end
    end

    assign upd_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign upd_sel   = sel_q;
    assign overrun   = overrun_q;

`ifdef TICK_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;
    logic [8:0] ovr_sum;

    always_comb begin
        ovr_sum   = {1'b0, ovr_cnt_q} + 9'(ovr_ev[0]) + 9'(ovr_ev[1]);
        ovr_cnt_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench: stimulus queues expected base_tick/upd_start cycles, a monitor checks them.
// Cycle 1 is the cycle in which reset is released.
module tb_game_tick_scheduler;

    localparam int DIV = 6;
`ifdef TICK_OVR_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic [3:0] spd_p1 = 4'd1;
    logic [3:0] spd_p2 = 4'd1;
    logic       upd_done;
    logic       base_tick, upd_start, upd_sel, busy;
    logic [1:0] overrun;
    logic [7:0] ovr_cnt;

    logic resp_done = 1'b0;
    logic force_done = 1'b0;
    assign upd_done = resp_done | force_done;

    int cyc;
    int checks = 0;
    int errors = 0;
    int done_dly = 1;
    int resp_cnt = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int   c;
        logic s;
    } start_t;
    start_t start_q[$];
    int     tick_q[$];

    game_tick_scheduler #(.DIV(DIV), .SPD_W(4)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .pause     (pause),
        .spd_p1    (spd_p1),
        .spd_p2    (spd_p2),
        .upd_done  (upd_done),
        .base_tick (base_tick),
        .upd_start (upd_start),
        .upd_sel   (upd_sel),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or posedge reset) begin
        if (reset) cyc <= 1;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Update engine model: upd_done pulses done_dly cycles after upd_start (0 = never).
    initial begin
        forever begin
            @(negedge Clk);
            resp_done = 1'b0;
            if (reset) begin
                resp_cnt = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_done = 1'b1;
            end else if (upd_start && done_dly > 0) begin
                resp_cnt = done_dly;
            end
        end
    end

    start_t se;
    int     te;
    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en && base_tick) begin
                if (tick_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected base_tick at cycle %0d", cyc);
                end else begin
                    te = tick_q.pop_front();
                    check("base_tick cycle", cyc, te);
                end
            end
            if (chk_en && upd_start) begin
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected upd_start at cycle %0d sel %0d", cyc, upd_sel);
                end else begin
                    se = start_q.pop_front();
                    check("upd_start cycle", cyc, se.c);
                    check("upd_sel", int'(upd_sel), int'(se.s));
                    check("busy at start", int'(busy), 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        force_done = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_s(input int c, input logic s);
        start_t e;
        e.c = c;
        e.s = s;
        start_q.push_back(e);
    endtask

    task automatic push_t(input int first, input int last);
        for (int t = first; t <= last; t += DIV) tick_q.push_back(t);
    endtask

    task automatic close(input int c);
        go(c + 1);
        chk_en = 1'b0;
        check("leftover upd_start", start_q.size(), 0);
        check("leftover base_tick", tick_q.size(), 0);
        start_q.delete();
        tick_q.delete();
    endtask

    initial begin
        // Both players every tick: strict alternation, no overrun.
        spd_p1 = 4'd1; spd_p2 = 4'd1; done_dly = 1;
        do_reset();
        check("reset overrun", int'(overrun), 0);
        check("reset busy", int'(busy), 0);
        push_t(6, 30);
        push_s(8, 0);  push_s(11, 1); push_s(14, 0); push_s(17, 1);
        push_s(20, 0); push_s(23, 1); push_s(26, 0); push_s(29, 1);
        chk_en = 1'b1;
        close(30);
        check("alt overrun", int'(overrun), 0);
        check("alt ovr_cnt", int'(ovr_cnt), 0);

        // P1 every third tick, P2 (speed 0) every tick.
        spd_p1 = 4'd3; spd_p2 = 4'd0; done_dly = 1;
        do_reset();
        push_t(6, 42);
        push_s(8, 1);  push_s(14, 1); push_s(20, 0); push_s(23, 1);
        push_s(26, 1); push_s(32, 1); push_s(38, 0); push_s(41, 1);
        chk_en = 1'b1;
        close(42);
        check("speed overrun", int'(overrun), 0);

        // Engine stalls 12 cycles: overruns, then round-robin resumes with P2.
        spd_p1 = 4'd1; spd_p2 = 4'd1; done_dly = 0;
        do_reset();
        push_t(6, 36);
        push_s(8, 0);  push_s(23, 1); push_s(26, 0);
        push_s(29, 1); push_s(32, 0); push_s(35, 1);
        chk_en = 1'b1;
        go(13);
        check("stall overrun early", int'(overrun), 2);
        check("stall ovr_cnt early", int'(ovr_cnt), OVR_EN ? 1 : 0);
        go(21);
        force_done = 1'b1;
        done_dly = 1;
        go(22);
        force_done = 1'b0;
        close(36);
        check("stall overrun", int'(overrun), 3);
        check("stall ovr_cnt", int'(ovr_cnt), OVR_EN ? 4 : 0);

        // Engine never finishes: counter climbs by 2 per tick and saturates.
        spd_p1 = 4'd1; spd_p2 = 4'd1; done_dly = 0;
        do_reset();
        push_t(6, 792);
        push_s(8, 0);
        chk_en = 1'b1;
        go(100);
        check("hold ovr_cnt 100", int'(ovr_cnt), OVR_EN ? 29 : 0);
        go(769);
        check("hold ovr_cnt 769", int'(ovr_cnt), OVR_EN ? 253 : 0);
        go(790);
        check("hold ovr_cnt sat", int'(ovr_cnt), OVR_EN ? 255 : 0);
        check("hold overrun", int'(overrun), 3);
        close(792);

        // Pause while a job is in WAIT: prescaler holds, pending job still drains.
        spd_p1 = 4'd1; spd_p2 = 4'd1; done_dly = 4;
        do_reset();
        tick_q.push_back(6);
        push_t(22, 40);
        push_s(8, 0);  push_s(14, 1); push_s(24, 0); push_s(27, 1);
        push_s(30, 0); push_s(33, 1); push_s(36, 0); push_s(39, 1);
        chk_en = 1'b1;
        go(12);
        pause = 1'b1;
        go(19);
        done_dly = 1;
        go(22);
        pause = 1'b0;
        close(40);
        check("pause overrun", int'(overrun), 0);

        // Lowering speed below the running count moves at the next tick.
        spd_p1 = 4'd4; spd_p2 = 4'd15; done_dly = 1;
        do_reset();
        push_t(6, 24);
        push_s(20, 0);
        chk_en = 1'b1;
        go(13);
        spd_p1 = 4'd2;
        close(24);

        // Reset in the middle of a stalled P2 job.
        spd_p1 = 4'd2; spd_p2 = 4'd1; done_dly = 0;
        do_reset();
        push_t(6, 18);
        push_s(8, 1);
        chk_en = 1'b1;
        close(19);
        check("pre-reset busy", int'(busy), 1);
        check("pre-reset upd_sel", int'(upd_sel), 1);
        check("pre-reset overrun", int'(overrun), 2);
        reset = 1'b1;
        #1;
        check("in-reset busy", int'(busy), 0);
        check("in-reset upd_sel", int'(upd_sel), 0);
        check("in-reset upd_start", int'(upd_start), 0);
        check("in-reset base_tick", int'(base_tick), 0);
        check("in-reset overrun", int'(overrun), 0);
        check("in-reset ovr_cnt", int'(ovr_cnt), 0);
        spd_p1 = 4'd1; spd_p2 = 4'd1; done_dly = 1;
        do_reset();
        push_t(6, 12);
        push_s(8, 0); push_s(11, 1); push_s(14, 0);
        chk_en = 1'b1;
        close(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
